// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor and reset release sequencer.
// Waits until the synchronized PLL lock has been stable for LOCK_STABLE_CYCLES,
// then releases the peripheral reset, the core reset and finally flags init done,
// with STAGE_DELAY cycles between stages. Loss of lock or a software request
// re-asserts every reset at once and restarts the sequence.
// Optional feature macro: PLL_LOCK_TIMEOUT_EN (sticky lock-timeout flag).
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_DELAY        = 16,
  parameter int unsigned LOCK_TIMEOUT       = 65536
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  input  logic       i_sw_reset_req,
  output logic       o_periph_reset_n,
  output logic       o_core_reset_n,
  output logic       o_init_done,
  output logic [7:0] o_lock_loss_cnt,
  output logic       o_pll_timeout
);

  localparam int unsigned MaxAB  = (LOCK_STABLE_CYCLES > STAGE_DELAY) ?
                                   LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int unsigned MaxAll = (MaxAB > LOCK_TIMEOUT) ? MaxAB : LOCK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxAll) + 1;

  localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] StageLast  = CntW'(STAGE_DELAY - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    StWaitLock,
    StStable,
    StRelPeriph,
    StRelCore,
    StRun
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_lock_s;
  logic            w_loss_inc;
  logic            w_periph_n_d;
  logic            w_core_n_d;
  logic            w_done_d;
  logic            r_periph_n;
  logic            r_core_n;
  logic            r_done;
  logic [7:0]      r_loss_cnt;
`ifdef PLL_LOCK_TIMEOUT_EN
  logic            r_timeout;
  logic            w_timeout_d;
`endif

  assign w_lock_s = r_sync2;

  // Two-flop synchronizer for the asynchronous PLL lock input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, shared counter and registered-output decode.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_loss_inc = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
    w_timeout_d = r_timeout;
`endif
    unique case (r_state)
      StWaitLock: begin
        w_cnt_d = '0;
        if (w_lock_s) begin
          w_state_d = StStable;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (r_cnt == TimeoutLast) begin
          // Saturate so the flag cannot re-trigger from a wrapped count.
          w_cnt_d     = r_cnt;
          w_timeout_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
`endif
      end
      StStable: begin
        if (!w_lock_s || i_sw_reset_req) begin
          w_state_d = StWaitLock;
          w_cnt_d   = '0;
        end else if (r_cnt == StableLast) begin
          w_state_d = StRelPeriph;
          w_cnt_d   = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
          w_timeout_d = 1'b0;
`endif
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      StRelPeriph, StRelCore, StRun: begin
        if (!w_lock_s || i_sw_reset_req) begin
          // Abort drops every reset together; only lock loss is counted.
          w_state_d  = StWaitLock;
          w_cnt_d    = '0;
          w_loss_inc = !w_lock_s;
        end else if (r_state == StRun) begin
          w_cnt_d = '0;
        end else if (r_cnt == StageLast) begin
          w_state_d = (r_state == StRelPeriph) ? StRelCore : StRun;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      default: begin
        w_state_d = StWaitLock;
        w_cnt_d   = '0;
      end
    endcase

    w_periph_n_d = (w_state_d == StRelPeriph) || (w_state_d == StRelCore) ||
                   (w_state_d == StRun);
    w_core_n_d   = (w_state_d == StRelCore) || (w_state_d == StRun);
    w_done_d     = (w_state_d == StRun);
  end

  // State, counter and output registers share one edge so outputs are glitch-free.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StWaitLock;
      r_cnt      <= '0;
      r_periph_n <= 1'b0;
      r_core_n   <= 1'b0;
      r_done     <= 1'b0;
      r_loss_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_periph_n <= w_periph_n_d;
      r_core_n   <= w_core_n_d;
      r_done     <= w_done_d;
      if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  // Sticky timeout flag, cleared only by reset or entry to peripheral release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_d;
    end
  end

  assign o_pll_timeout = r_timeout;
`else
  assign o_pll_timeout = 1'b0;
`endif

  assign o_periph_reset_n = r_periph_n;
  assign o_core_reset_n   = r_core_n;
  assign o_init_done      = r_done;
  assign o_lock_loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: table-driven release timing,
// hand-written abort/glitch/timeout sequences and randomized stimulus against
// an age-based reference model.
module tb_pll_reset_sequencer;

  localparam int LSC = 8;
  localparam int SD  = 4;
  localparam int LTO = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       sw;
  logic       periph_n;
  logic       core_n;
  logic       done;
  logic [7:0] loss;
  logic       tmo;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_DELAY       (SD),
    .LOCK_TIMEOUT      (LTO)
  ) u_dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_pll_lock      (lock),
    .i_sw_reset_req  (sw),
    .o_periph_reset_n(periph_n),
    .o_core_reset_n  (core_n),
    .o_init_done     (done),
    .o_lock_loss_cnt (loss),
    .o_pll_timeout   (tmo)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  // Reference model: age = edges since a stable-lock window began (-1 = waiting).
  bit m_s1, m_s2;
  int m_age = -1;
  int m_loss = 0;
  int m_wait = 0;
  bit m_tmo = 0;

  function automatic void model_edge(bit r, bit l, bit s);
    bit ls;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_age = -1; m_loss = 0; m_wait = 0; m_tmo = 0;
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = l;
    if (m_age < 0) begin
      if (ls) m_age = 0;
`ifdef PLL_LOCK_TIMEOUT_EN
      else if (m_wait == LTO - 1) m_tmo = 1;
      else m_wait++;
`endif
    end else if (!ls || s) begin
      if (m_age >= LSC && !ls && m_loss < 255) m_loss++;
      m_age  = -1;
      m_wait = 0;
    end else begin
      if (m_age < LSC + 2 * SD) m_age++;
      if (m_age == LSC) m_tmo = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, lock, sw);
    edge_no++;
    #1;
    check("model_periph_n", {31'd0, periph_n}, (m_age >= LSC) ? 1 : 0);
    check("model_core_n", {31'd0, core_n}, (m_age >= LSC + SD) ? 1 : 0);
    check("model_init_done", {31'd0, done}, (m_age >= LSC + 2 * SD) ? 1 : 0);
    check("model_loss_cnt", {24'd0, loss}, m_loss);
    check("model_timeout", {31'd0, tmo}, {31'd0, m_tmo});
  endtask

  task automatic do_reset();
    rst = 1; lock = 0; sw = 0;
    step();
    step();
    rst = 0;
    edge_no = 0;
  endtask

  task automatic step_to(input int e);
    while (edge_no < e) step();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    check("wait_done_bound", {31'd0, done}, 1);
  endtask

  typedef struct {
    int edge_n;
    bit p;
    bit c;
    bit d;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{edge_n: 1,  p: 0, c: 0, d: 0};
    tbl[1] = '{edge_n: 10, p: 0, c: 0, d: 0};
    tbl[2] = '{edge_n: 11, p: 1, c: 0, d: 0};
    tbl[3] = '{edge_n: 14, p: 1, c: 0, d: 0};
    tbl[4] = '{edge_n: 15, p: 1, c: 1, d: 0};
    tbl[5] = '{edge_n: 18, p: 1, c: 1, d: 0};
    tbl[6] = '{edge_n: 19, p: 1, c: 1, d: 1};
    tbl[7] = '{edge_n: 25, p: 1, c: 1, d: 1};

    // Reset state.
    do_reset();
    check("rst_periph_n", {31'd0, periph_n}, 0);
    check("rst_core_n", {31'd0, core_n}, 0);
    check("rst_init_done", {31'd0, done}, 0);
    check("rst_loss_cnt", {24'd0, loss}, 0);
    check("rst_timeout", {31'd0, tmo}, 0);

    // Clean lock rise: release timing from the table.
    lock = 1;
    for (int i = 0; i < 8; i++) begin
      step_to(tbl[i].edge_n);
      check("tbl_periph_n", {31'd0, periph_n}, {31'd0, tbl[i].p});
      check("tbl_core_n", {31'd0, core_n}, {31'd0, tbl[i].c});
      check("tbl_init_done", {31'd0, done}, {31'd0, tbl[i].d});
    end
    check("tbl_loss_cnt", {24'd0, loss}, 0);

    // Lock glitch in the stable window restarts the full window.
    do_reset();
    lock = 1;
    step_to(6);
    lock = 0;
    step_to(8);
    lock = 1;
    step_to(18);
    check("glitch_periph_early", {31'd0, periph_n}, 0);
    step_to(19);
    check("glitch_periph_release", {31'd0, periph_n}, 1);
    check("glitch_loss_cnt", {24'd0, loss}, 0);

    // Software request in RUN: immediate drop, rerun, no loss count.
    do_reset();
    lock = 1;
    wait_done();
    edge_no = 0;
    sw = 1;
    step();
    sw = 0;
    check("sw_periph_n", {31'd0, periph_n}, 0);
    check("sw_core_n", {31'd0, core_n}, 0);
    check("sw_init_done", {31'd0, done}, 0);
    step_to(9);
    check("sw_rerun_early", {31'd0, periph_n}, 0);
    step_to(10);
    check("sw_rerun_periph", {31'd0, periph_n}, 1);
    wait_done();
    check("sw_loss_cnt", {24'd0, loss}, 0);

    // Simultaneous lock loss and software request in REL_CORE.
    do_reset();
    lock = 1;
    step_to(14);
    lock = 0;
    step_to(16);
    check("both_in_rel_core", {31'd0, core_n}, 1);
    sw = 1;
    step();
    sw = 0;
    check("both_periph_n", {31'd0, periph_n}, 0);
    check("both_core_n", {31'd0, core_n}, 0);
    check("both_loss_cnt", {24'd0, loss}, 1);

    // Reset mid-flight clears the loss counter.
    rst = 1;
    step();
    rst = 0;
    check("midreset_loss_cnt", {24'd0, loss}, 0);

    // Lock loss in RUN, repeated until the counter saturates.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      lock = 1;
      wait_done();
      lock = 0;
      step();
      step();
      if (k == 0) check("loss_two_edges_periph", {31'd0, periph_n}, 1);
      step();
      if (k == 0) begin
        check("loss_periph_n", {31'd0, periph_n}, 0);
        check("loss_core_n", {31'd0, core_n}, 0);
        check("loss_init_done", {31'd0, done}, 0);
        check("loss_cnt_first", {24'd0, loss}, 1);
      end
    end
    check("loss_cnt_saturated", {24'd0, loss}, 255);

    // Lock timeout behaviour with lock held low after reset.
    do_reset();
`ifdef PLL_LOCK_TIMEOUT_EN
    step_to(31);
    check("timeout_early", {31'd0, tmo}, 0);
    step_to(32);
    check("timeout_set", {31'd0, tmo}, 1);
    step_to(45);
    check("timeout_sticky", {31'd0, tmo}, 1);
    lock = 1;
    edge_no = 0;
    step_to(10);
    check("timeout_held_stable", {31'd0, tmo}, 1);
    step_to(11);
    check("timeout_cleared", {31'd0, tmo}, 0);
`else
    step_to(45);
    check("timeout_tied_low", {31'd0, tmo}, 0);
`endif

    // Randomized lock/sw/reset stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) lock = ~lock;
      sw  = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 0;
    sw  = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
